sad_sequencer: RTL and testbench



---
 rtl/sad_pkg.sv | 11 +
 rtl/sad_sequencer_if.sv | 18 +
 rtl/abs_diff_4bit.sv | 10 +
 rtl/sad_sequencer.sv | 77 +++++++
 tb/tb_sad_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sad_pkg.sv
// sad_pkg: shared state encoding and operand constants for the SAD sequencer
package sad_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;
    localparam int OPW = 4;
    localparam logic [OPW-1:0] ABS_MAX = 4'd15;
endpackage

// File: rtl/sad_sequencer_if.sv
// sad_sequencer_if: operand handshake, control and result bundle of the SAD sequencer
interface sad_sequencer_if import sad_pkg::*; #(parameter int ACC_W = 8);
    logic             start;
    logic             abort;
    logic [OPW-1:0]   a;
    logic [OPW-1:0]   b;
    logic             in_valid;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] sad;
    logic [OPW-1:0]   max_abs;
    logic             sat;
    modport master (output start, abort, a, b, in_valid,
                    input  in_ready, busy, done, sad, max_abs, sat);
    modport slave  (input  start, abort, a, b, in_valid,
                    output in_ready, busy, done, sad, max_abs, sat);
endinterface

// File: rtl/abs_diff_4bit.sv
// abs_diff_4bit: |a-b| of two signed operands, computed one bit wider so it never overflows
module abs_diff_4bit import sad_pkg::*; (
    input  logic [OPW-1:0] i_a,
    input  logic [OPW-1:0] i_b,
    output logic [OPW-1:0] o_abs
);
    logic signed [OPW:0] w_d;
    assign w_d   = $signed({i_a[OPW-1], i_a}) - $signed({i_b[OPW-1], i_b});
    assign o_abs = w_d[OPW] ? OPW'(-w_d) : w_d[OPW-1:0];
endmodule

// File: rtl/sad_sequencer.sv
// sad_sequencer: accepts a burst of operand pairs and accumulates a saturating SAD and peak |A-B|
module sad_sequencer import sad_pkg::*; #(
    parameter int N_PAIRS = 8,
    parameter int ACC_W   = 8
) (
    input logic            clk,
    input logic            rst,
    sad_sequencer_if.slave bus
);
    state_t           r_state, w_next;
    logic [7:0]       r_cnt;
    logic [OPW-1:0]   r_s1;
    logic             r_s1_v;
    logic [ACC_W-1:0] r_sad;
    logic [OPW-1:0]   r_max;
    logic             r_sat;
    logic [OPW-1:0]   w_abs;
    logic [ACC_W:0]   w_sum;
    logic             w_accept, w_last, w_start, w_abort;

    abs_diff_4bit u_abs (.i_a(bus.a), .i_b(bus.b), .o_abs(w_abs));

    assign w_accept = bus.in_valid && r_state == RUN;
    assign w_last   = w_accept && r_cnt == 8'(N_PAIRS - 1);
    assign w_start  = bus.start && r_state == IDLE;
    assign w_abort  = bus.abort && (r_state == RUN || r_state == DRAIN);
    // carry bit of the widened sum flags accumulator overflow
    assign w_sum    = {1'b0, r_sad} + (ACC_W+1)'(r_s1);

    always_comb begin
        w_next       = r_state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        w_next       = w_abort ? IDLE :
                       w_start ? RUN :
                       w_last ? DRAIN :
                       r_state == DRAIN ? FIN :
                       r_state == FIN ? IDLE : r_state;
        bus.in_ready = r_state == RUN;
        bus.busy     = r_state != IDLE;
        bus.done     = r_state == FIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_s1    <= '0;
            r_s1_v  <= 1'b0;
            r_sad   <= '0;
            r_max   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_s1_v  <= w_accept && !w_abort;
            if (w_accept) r_s1 <= w_abs;
            if (w_start) begin
                r_cnt <= '0;
                r_sad <= '0;
                r_max <= '0;
                r_sat <= 1'b0;
            end else begin
                if (w_accept) r_cnt <= r_cnt + 8'd1;
                if (r_s1_v) begin
                    r_sad <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
                    r_sat <= r_sat | w_sum[ACC_W];
                    r_max <= r_s1 > r_max ? r_s1 : r_max;
                end
            end
        end
    end

    assign bus.sad     = r_sad;
    assign bus.max_abs = r_max;
    assign bus.sat     = r_sat;
endmodule

// File: tb/tb_sad_sequencer.sv
// tb_sad_sequencer: three parameterisations driven one at a time, checked against a burst-level arithmetic model
module tb_sad_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [3:0] a = '0, b = '0;
    int sel = 0;
    int n_chk = 0, n_fail = 0;
    int pa [16];
    int pb [16];
    logic rdy, busy, done, sat;
    logic [15:0] o_sad;
    logic [3:0]  o_max;

    always #5 clk = ~clk;

    sad_sequencer_if #(.ACC_W(8)) if0 ();
    sad_sequencer_if #(.ACC_W(4)) if1 ();
    sad_sequencer_if #(.ACC_W(8)) if2 ();

    sad_sequencer #(.N_PAIRS(4), .ACC_W(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
    sad_sequencer #(.N_PAIRS(2), .ACC_W(4)) u1 (.clk(clk), .rst(rst), .bus(if1));
    sad_sequencer #(.N_PAIRS(1), .ACC_W(8)) u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.start = start && sel == 0;
    assign if1.start = start && sel == 1;
    assign if2.start = start && sel == 2;
    assign if0.abort = abort && sel == 0;
    assign if1.abort = abort && sel == 1;
    assign if2.abort = abort && sel == 2;
    assign if0.in_valid = in_valid && sel == 0;
    assign if1.in_valid = in_valid && sel == 1;
    assign if2.in_valid = in_valid && sel == 2;
    assign if0.a = a;
    assign if1.a = a;
    assign if2.a = a;
    assign if0.b = b;
    assign if1.b = b;
    assign if2.b = b;

    always_comb begin
        rdy   = sel == 0 ? if0.in_ready : sel == 1 ? if1.in_ready : if2.in_ready;
        busy  = sel == 0 ? if0.busy : sel == 1 ? if1.busy : if2.busy;
        done  = sel == 0 ? if0.done : sel == 1 ? if1.done : if2.done;
        sat   = sel == 0 ? if0.sat : sel == 1 ? if1.sat : if2.sat;
        o_sad = sel == 0 ? 16'(if0.sad) : sel == 1 ? 16'(if1.sad) : 16'(if2.sad);
        o_max = sel == 0 ? if0.max_abs : sel == 1 ? if1.max_abs : if2.max_abs;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (sel=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic int sx(input int v);
        return v >= 8 ? v - 16 : v;
    endfunction

    function automatic int absd(input int x, input int y);
        int d = sx(x) - sx(y);
        return d < 0 ? -d : d;
    endfunction

    task automatic rand_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            pa[i] = int'($urandom_range(0, 15));
            pb[i] = int'($urandom_range(0, 15));
        end
    endtask

    // gmode: 0 no gaps, 1 three idle cycles before the third pair, 2 random gaps
    task automatic burst(input int n, input int accw, input int gmode,
                         input bit st_mid, input bit st_fin, input bit ab_st);
        int tot = 0, mx = 0, emax = (1 << accw) - 1, esad;
        start = 1'b1;
        abort = ab_st;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_busy", busy, 1);
        check("start_sad", o_sad, 0);
        check("start_max", o_max, 0);
        check("start_sat", sat, 0);
        for (int i = 0; i < n; i++) begin
            int g = gmode == 1 ? (i == 2 ? 3 : 0) : gmode == 2 ? int'($urandom_range(0, 2)) : 0;
            in_valid = 1'b0;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                check("gap_ready", rdy, 1);
            end
            a = 4'(pa[i]);
            b = 4'(pb[i]);
            in_valid = 1'b1;
            start = st_mid && i == 1;
            tot += absd(pa[i], pb[i]);
            if (absd(pa[i], pb[i]) > mx) mx = absd(pa[i], pb[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        esad = tot > emax ? emax : tot;
        check("drain_ready", rdy, 0);
        check("drain_done", done, 0);
        @(negedge clk);
        check("done", done, 1);
        check("sad", o_sad, esad);
        check("max_abs", o_max, mx);
        check("sat", sat, int'(tot > emax));
        start = st_fin;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("hold_sad", o_sad, esad);
        check("hold_sat", sat, int'(tot > emax));
    endtask

    task automatic abort_test();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", rdy, 0);
        for (int k = 0; k < 4; k++) begin
            check("abort_no_done", done, 0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            pa[i] = 0;
            pb[i] = 0;
        end
        burst(4, 8, 0, 0, 0, 0);
    endtask

    task automatic reset_test();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'd7;
        b = 4'd8;
        in_valid = 1'b1;
        @(negedge clk);
        a = 4'd0;
        b = 4'd5;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_sad", o_sad, 15);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", rdy, 0);
        check("rst_sad", o_sad, 0);
        check("rst_max", o_max, 0);
        check("rst_sat", sat, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", done, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_ready", rdy, 0);
        check("reset_done", done, 0);
        check("reset_sad", o_sad, 0);
        check("reset_max", o_max, 0);
        check("reset_sat", sat, 0);
        rst = 1'b0;
        @(negedge clk);
        pa[0:3] = '{4, 15, 8, 7};
        pb[0:3] = '{0, 0, 0, 8};
        burst(4, 8, 0, 0, 0, 0);
        burst(4, 8, 1, 0, 0, 0);
        rand_pairs(4);
        burst(4, 8, 0, 1, 1, 1);
        for (int r = 0; r < 6; r++) begin
            rand_pairs(4);
            burst(4, 8, 2, r[0], r[1], r[2]);
        end
        abort_test();
        reset_test();
        sel = 1;
        @(negedge clk);
        pa[0:1] = '{7, 7};
        pb[0:1] = '{8, 8};
        burst(2, 4, 0, 0, 0, 0);
        for (int r = 0; r < 8; r++) begin
            rand_pairs(2);
            burst(2, 4, 2, r[0], r[1], 0);
        end
        sel = 2;
        @(negedge clk);
        pa[0] = 10;
        pb[0] = 5;
        burst(1, 8, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            rand_pairs(1);
            burst(1, 8, 2, 0, r[0], 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
